// File: rtl/bcd_serial_add_ctrl_pkg.sv
// Shared constants for the digit-serial BCD adder: digit width, FSM encodings
// and the largest legal BCD digit value.
package bcd_serial_add_ctrl_pkg;

    localparam int BCD_DIGIT_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [BCD_DIGIT_W-1:0] BCD_MAX = 4'd9;

    function automatic logic digit_invalid(input logic [BCD_DIGIT_W-1:0] d);
        return d > BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_serial_add_ctrl_adder.sv
// Single-digit combinational BCD adder: binary add, then +6 correction when
// the raw sum exceeds 9.
module bcd_adder
    import bcd_serial_add_ctrl_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] a,
    input  logic [BCD_DIGIT_W-1:0] b,
    input  logic                   cin,
    output logic [BCD_DIGIT_W-1:0] sum,
    output logic                   cout
);

    logic [BCD_DIGIT_W:0] raw;
    logic [BCD_DIGIT_W:0] adj;

    always_comb begin
        raw  = {1'b0, a} + {1'b0, b} + {{BCD_DIGIT_W{1'b0}}, cin};
        adj  = raw;
        cout = 1'b0;
        if (raw > {1'b0, BCD_MAX}) begin
            adj  = raw + 5'd6;
            cout = 1'b1;
        end
        sum = adj[BCD_DIGIT_W-1:0];
    end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial multi-digit BCD adder: one digit per clock, LS digit first,
// with the inter-digit carry registered; result published atomically on done.
module bcd_serial_add_ctrl
    import bcd_serial_add_ctrl_pkg::*;
#(
    parameter int NDIGITS = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [NDIGITS*BCD_DIGIT_W-1:0] a,
    input  logic [NDIGITS*BCD_DIGIT_W-1:0] b,
    input  logic                           cin,
    output logic                           busy,
    output logic                           done,
    output logic [NDIGITS*BCD_DIGIT_W-1:0] sum,
    output logic                           cout,
    output logic                           err,
    output logic [1:0]                     state_dbg
);

    // Handshake: start is accepted on any rising edge where the FSM is in IDLE
    // or DONE; busy is high for exactly NDIGITS cycles afterwards, then done
    // pulses for one cycle with sum/cout/err already updated. start during
    // busy is dropped, and a/b are only sampled on the accepting edge.

    localparam int W     = NDIGITS * BCD_DIGIT_W;
    localparam int CNT_W = $clog2(NDIGITS) + 1;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     a_sr_q, a_sr_d;
    logic [W-1:0]     b_sr_q, b_sr_d;
    logic [W-1:0]     res_q, res_d;
    logic             carry_q, carry_d;
    logic             err_r_q, err_r_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             err_q, err_d;

    logic [BCD_DIGIT_W-1:0] add_sum;
    logic                   add_cout;
    logic                   any_bad;
    logic [W-1:0]           res_shift;

    bcd_adder u_adder (
        .a    (a_sr_q[BCD_DIGIT_W-1:0]),
        .b    (b_sr_q[BCD_DIGIT_W-1:0]),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        any_bad = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (digit_invalid(a[i*BCD_DIGIT_W +: BCD_DIGIT_W]) ||
                digit_invalid(b[i*BCD_DIGIT_W +: BCD_DIGIT_W])) begin
                any_bad = 1'b1;
            end
        end
    end

    // New digit enters at the top so after NDIGITS shifts digit 0 sits at [3:0].
    assign res_shift = (res_q >> BCD_DIGIT_W) | (W'(add_sum) << (W - BCD_DIGIT_W));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        carry_d = carry_q;
        err_r_d = err_r_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    err_r_d = any_bad;
                    state_d = ST_ADD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADD: begin
                res_d   = res_shift;
                a_sr_d  = a_sr_q >> BCD_DIGIT_W;
                b_sr_d  = b_sr_q >> BCD_DIGIT_W;
                carry_d = add_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(NDIGITS - 1)) begin
                    sum_d   = res_shift;
                    cout_d  = add_cout;
                    err_d   = err_r_q;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            err_r_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            err_r_q <= err_r_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
        end
    end

    assign busy      = (state_q == ST_ADD);
    assign done      = (state_q == ST_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign err       = err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Scoreboard bench for bcd_serial_add_ctrl: NDIGITS=4 main instance plus an
// NDIGITS=1 instance for the single-digit corner.
module tb_bcd_serial_add_ctrl;

    localparam int N  = 4;
    localparam int W  = N * 4;
    localparam int EW = W + 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         cin;
    logic         busy, done, cout, err;
    logic [W-1:0] sum;
    logic [1:0]   state_dbg;

    logic       start1;
    logic [3:0] a1, b1;
    logic       cin1;
    logic       busy1, done1, cout1, err1;
    logic [3:0] sum1;
    logic [1:0] state_dbg1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [EW-1:0] exp_q[$];
    int            exp_cyc_q[$];

    always #5 clk = ~clk;

    bcd_serial_add_ctrl #(.NDIGITS(N)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err),
        .state_dbg(state_dbg)
    );

    bcd_serial_add_ctrl #(.NDIGITS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .err(err1),
        .state_dbg(state_dbg1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per done pulse, checks value and timing.
    initial begin
        logic [EW-1:0] e;
        int            ec;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'(0));
                end else begin
                    e  = exp_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    chk("sum",  64'(sum),  64'(e[W+1:2]));
                    chk("cout", 64'(cout), 64'(e[1]));
                    chk("err",  64'(err),  64'(e[0]));
                    chk("done_cycle", 64'(cyc), 64'(ec));
                end
            end
        end
    end

    task automatic push_exp(input logic [W-1:0] s, input logic c, input logic e, input int at);
        exp_q.push_back({s, c, e});
        exp_cyc_q.push_back(at);
    endtask

    // Called at a negedge: raises start with operands, drops it one cycle later.
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                         input logic [W-1:0] es, input logic ec, input logic ee);
        a = av; b = bv; cin = ci; start = 1'b1;
        push_exp(es, ec, ee, cyc + 1 + N);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'(0));
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy",  64'(busy),      64'(0));
        chk("rst_done",  64'(done),      64'(0));
        chk("rst_sum",   64'(sum),       64'(0));
        chk("rst_cout",  64'(cout),      64'(0));
        chk("rst_err",   64'(err),       64'(0));
        chk("rst_state", 64'(state_dbg), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // 1234 + 5678 with busy profile checked directly
        issue(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
        chk("busy_c1", 64'(busy), 64'(1));
        for (int i = 2; i <= N; i++) begin
            @(negedge clk);
            chk("busy_mid", 64'(busy), 64'(1));
        end
        @(negedge clk);
        chk("busy_low_at_done", 64'(busy), 64'(0));
        drain();

        issue(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        drain();
        issue(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
        drain();

        // start held through the op; a/b change after the accepting edge
        a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
        push_exp(16'h6912, 1'b0, 1'b0, cyc + 1 + N);
        push_exp(16'h2222, 1'b0, 1'b0, cyc + 2 + 2 * N);
        @(negedge clk);
        a = 16'h1111; b = 16'h1111;
        repeat (N + 1) @(negedge clk);
        start = 1'b0;
        drain();

        // reset during the second ADD cycle abandons the operation
        a = 16'h0500; b = 16'h0500; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy",  64'(busy),      64'(0));
        chk("mid_rst_done",  64'(done),      64'(0));
        chk("mid_rst_sum",   64'(sum),       64'(0));
        chk("mid_rst_cout",  64'(cout),      64'(0));
        chk("mid_rst_err",   64'(err),       64'(0));
        chk("mid_rst_state", 64'(state_dbg), 64'(0));
        rst = 1'b0;
        repeat (2 * N + 2) @(negedge clk);

        issue(16'h00F0, 16'h0000, 1'b0, 16'h0150, 1'b0, 1'b1);
        drain();
        issue(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
        drain();

        // single-digit instance: done two cycles after start
        a1 = 4'h7; b1 = 4'h5; cin1 = 1'b1; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("n1_busy", 64'(busy1), 64'(1));
        chk("n1_done_early", 64'(done1), 64'(0));
        @(negedge clk);
        chk("n1_done", 64'(done1), 64'(1));
        chk("n1_sum",  64'(sum1),  64'(4'h3));
        chk("n1_cout", 64'(cout1), 64'(1));
        chk("n1_err",  64'(err1),  64'(0));
        @(negedge clk);
        chk("n1_done_pulse", 64'(done1), 64'(0));

        repeat (3) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
